// File: rtl/verifuck_pkg.sv
// Shared definitions for the BF processor I/O path: byte width, TX FSM state
// encoding and a parameter sanity check used at elaboration time.
package verifuck_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Depth must be a power of two >= 4, the start strobe at least one cycle
    // long, and the halt margin must leave at least one usable slot.
    function automatic bit params_legal(input int depth, input int hold, input int margin);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (hold >= 1) && (margin >= 1) && (margin <= depth - 1);
    endfunction

endpackage

// File: rtl/stdout_tx_sched_if.sv
// Processor-stdout and uart_tx handshake signals seen by the TX scheduler.
interface stdout_tx_sched_if;
    import verifuck_pkg::*;

    logic [BYTE_W-1:0] stdout;
    logic              stdout_en;
    logic              cpu_en;
    logic [BYTE_W-1:0] uart_data;
    logic              uart_start;
    logic              uart_ready;

    // The scheduler side.
    modport slave (
        input  stdout, stdout_en, uart_ready,
        output cpu_en, uart_data, uart_start
    );

    // The processor/UART environment side.
    modport master (
        output stdout, stdout_en, uart_ready,
        input  cpu_en, uart_data, uart_start
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head_reg;
    logic [AW-1:0]    tail_reg;
    logic [AW:0]      count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[head_reg];
    assign count = count_reg;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail_reg] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_en) tail_reg <= tail_reg + AW'(1);
            if (rd_en) head_reg <= head_reg + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stdout_tx_sched.sv
// Buffers bytes from the processor's stdout port and feeds them one at a time
// to uart_tx, halting the processor only when the buffer is nearly full.
module stdout_tx_sched
    import verifuck_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int START_HOLD  = 2,
    parameter int HALT_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    stdout_tx_sched_if.slave       bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = CW + 1;
    localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_START     = START;
    localparam logic [1:0] ST_WAIT_BUSY = WAIT_BUSY;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

    if (!params_legal(DEPTH, START_HOLD, HALT_MARGIN)) begin : g_bad_params
        $error("stdout_tx_sched: illegal DEPTH/START_HOLD/HALT_MARGIN combination");
    end

    logic              en_prev_reg;
    logic              cpu_en_reg;
    logic              overflow_reg;
    logic [1:0]        state_reg;
    logic              start_reg;
    logic [BYTE_W-1:0] data_reg;
    logic [HW-1:0]     hold_reg;

    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] head_data;
    logic [CW-1:0]     count_now;
    logic [CW-1:0]     count_next;
    logic [FW-1:0]     free_next;

    // Only the rising edge of the stdout_en level is a byte.
    assign push_req = bus.stdout_en & ~en_prev_reg;
    assign pop      = (state_reg == ST_IDLE) & ~fifo_empty & bus.uart_ready;
    assign push_ok  = push_req & (~fifo_full | pop);

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (bus.stdout),
        .rdata (head_data),
        .count (count_now),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy after this edge, so cpu_en reacts in the same cycle as the push.
    always_comb begin
        count_next = count_now;
        case ({push_ok, pop})
            2'b10:   count_next = count_now + CW'(1);
            2'b01:   count_next = count_now - CW'(1);
            default: count_next = count_now;
        endcase
        free_next = FW'(DEPTH) - {1'b0, count_next};
    end

    // Edge detect history, processor backpressure and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_prev_reg  <= 1'b0;
            cpu_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            en_prev_reg <= bus.stdout_en;
            cpu_en_reg  <= (free_next > FW'(HALT_MARGIN));
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // TX sequencer: launch a byte, stretch the start strobe, then follow
    // uart_ready through busy and back to idle before launching the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            start_reg <= 1'b0;
            data_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        data_reg  <= head_data;
                        start_reg <= 1'b1;
                        hold_reg  <= HW'(START_HOLD - 1);
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (hold_reg != '0) begin
                        hold_reg <= hold_reg - HW'(1);
                    end else begin
                        start_reg <= 1'b0;
                        state_reg <= bus.uart_ready ? ST_WAIT_BUSY : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!bus.uart_ready) state_reg <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.uart_ready) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_en     = cpu_en_reg;
    assign bus.uart_start = start_reg;
    assign bus.uart_data  = data_reg;
    assign fifo_count     = count_now;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_stdout_tx_sched.sv
// Testbench for stdout_tx_sched: a behavioural uart_tx model captures each
// launched byte; expected bytes are queued as stimulus is driven and matched
// in order against what the model received.
module tb_stdout_tx_sched;
    import verifuck_pkg::*;

    localparam int DEPTH       = 16;
    localparam int START_HOLD  = 2;
    localparam int HALT_MARGIN = 2;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    stdout_tx_sched_if bus();

    stdout_tx_sched #(
        .DEPTH       (DEPTH),
        .START_HOLD  (START_HOLD),
        .HALT_MARGIN (HALT_MARGIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // UART model state and scoreboard queues
    int         busy_len    = 4;
    logic       force_busy  = 1'b0;
    logic       model_ready = 1'b1;
    int         busy_cnt    = 0;
    logic       start_prev  = 1'b0;
    int         pulse_len   = 0;
    int         max_count   = 0;
    int         data_glitches = 0;
    logic [7:0] cur_byte    = 8'h00;
    logic [7:0] rx_q[$];
    int         pulse_q[$];
    logic [7:0] exp_q[$];

    assign bus.uart_ready = model_ready & ~force_busy;

    // uart_tx model, sampled on the falling edge: capture on the strobe's rise,
    // stay busy busy_len cycles, record strobe widths and data stability.
    always @(negedge clk) begin
        start_prev <= bus.uart_start;
        if (int'(fifo_count) > max_count) max_count <= int'(fifo_count);
        if (bus.uart_start && !start_prev) begin
            rx_q.push_back(bus.uart_data);
            cur_byte    <= bus.uart_data;
            model_ready <= 1'b0;
            busy_cnt    <= busy_len;
            pulse_len   <= 1;
        end else begin
            if (bus.uart_start) pulse_len <= pulse_len + 1;
            if ((bus.uart_start || !model_ready) && bus.uart_data !== cur_byte)
                data_glitches <= data_glitches + 1;
            if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else if (busy_cnt == 1) begin
                busy_cnt    <= 0;
                model_ready <= 1'b1;
            end
        end
        if (!bus.uart_start && start_prev) pulse_q.push_back(pulse_len);
    end

    task automatic clear_sb();
        #1;
        rx_q.delete();
        pulse_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bus.stdout_en = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        clear_sb();
        @(negedge clk);
    endtask

    // Drives one rising edge of stdout_en; returns just after the sampling edge.
    task automatic push_byte(input logic [7:0] b, input bit expect_ok);
        bus.stdout    = b;
        bus.stdout_en = 1'b1;
        if (expect_ok) exp_q.push_back(b);
        @(negedge clk);
        bus.stdout_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b expected 0", bus.cpu_en); end
        if (bus.uart_start !== 1'b0) begin n_fail++; $display("FAIL reset_uart_start: got %b expected 0", bus.uart_start); end
        if (bus.uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_uart_data: got %h expected 00", bus.uart_data); end
        if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        n_checks++;
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL release_cpu_en_early: got %b expected 0", bus.cpu_en); end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL release_cpu_en: got %b expected 1", bus.cpu_en); end
        clear_sb();
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        bit ok;
        int g0 = data_glitches;
        logic [7:0] got, exp;
        push_byte(8'h41, 1'b1);
        n_checks += 2;
        if (fifo_count !== CW'(1)) begin n_fail++; $display("FAIL single_count_E: got %0d expected 1", fifo_count); end
        if (bus.uart_start !== 1'b0) begin n_fail++; $display("FAIL single_start_E: got %b expected 0", bus.uart_start); end
        @(negedge clk);
        n_checks += 3;
        if (bus.uart_start !== 1'b1) begin n_fail++; $display("FAIL single_start_E1: got %b expected 1", bus.uart_start); end
        if (fifo_count !== '0) begin n_fail++; $display("FAIL single_count_E1: got %0d expected 0", fifo_count); end
        if (bus.uart_data !== 8'h41) begin n_fail++; $display("FAIL single_data_E1: got %h expected 41", bus.uart_data); end
        @(negedge clk);
        n_checks++;
        if (bus.uart_start !== 1'b1) begin n_fail++; $display("FAIL single_start_E2: got %b expected 1", bus.uart_start); end
        @(negedge clk);
        n_checks++;
        if (bus.uart_start !== 1'b0) begin n_fail++; $display("FAIL single_start_E3: got %b expected 0", bus.uart_start); end
        wait_rx(1, 50, ok);
        repeat (busy_len + 10) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes expected 1", rx_q.size()); end
        if (ok) begin
            got = rx_q.pop_front();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL single_byte: got %h expected %h", got, exp); end
        end
        n_checks += 3;
        if (pulse_q.size() != 1 || pulse_q[0] != START_HOLD) begin
            n_fail++; $display("FAIL single_pulse: got %0d pulses (first %0d) expected 1 of %0d",
                               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1, START_HOLD);
        end
        if (data_glitches != g0) begin n_fail++; $display("FAIL single_data_stable: got %0d changes expected 0", data_glitches - g0); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b expected 0", overflow); end
        clear_sb();
        $display("test_single_byte done");
    endtask

    task automatic test_level_hold();
        bus.stdout    = 8'h55;
        bus.stdout_en = 1'b1;
        exp_q.push_back(8'h55);
        repeat (20) @(negedge clk);
        bus.stdout_en = 1'b0;
        repeat (40) @(negedge clk);
        n_checks += 2;
        if (rx_q.size() != 1) begin n_fail++; $display("FAIL level_count: got %0d bytes expected 1", rx_q.size()); end
        if (pulse_q.size() != 1) begin n_fail++; $display("FAIL level_pulses: got %0d bursts expected 1", pulse_q.size()); end
        if (rx_q.size() > 0) begin
            logic [7:0] got = rx_q.pop_front();
            logic [7:0] exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL level_byte: got %h expected %h", got, exp); end
        end
        clear_sb();
        $display("test_level_hold done");
    endtask

    task automatic test_burst_order();
        bit ok;
        int g0 = data_glitches;
        busy_len = 100;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i), 1'b1);
            @(negedge clk);
        end
        wait_rx(5, 700, ok);
        repeat (busy_len + 10) @(negedge clk);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL burst_timeout: got %0d bytes expected 5", rx_q.size()); end
        if (max_count != 4) begin n_fail++; $display("FAIL burst_peak: got %0d expected 4", max_count); end
        if (data_glitches != g0) begin n_fail++; $display("FAIL burst_data_stable: got %0d changes expected 0", data_glitches - g0); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] got = rx_q.pop_front();
            logic [7:0] exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL burst_order: got %h expected %h", got, exp); end
        end
        foreach (pulse_q[i]) begin
            n_checks++;
            if (pulse_q[i] != START_HOLD) begin n_fail++; $display("FAIL burst_pulse[%0d]: got %0d expected %0d", i, pulse_q[i], START_HOLD); end
        end
        busy_len = 4;
        clear_sb();
        $display("test_burst_order done");
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset(3);
        force_busy = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            push_byte(8'h10 + 8'(i), i <= 16);
            if (i == 13) begin
                n_checks++;
                if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL bp_cpu_en_13: got %b expected 1", bus.cpu_en); end
            end
            if (i == 14) begin
                n_checks += 2;
                if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL bp_cpu_en_14: got %b expected 0", bus.cpu_en); end
                if (fifo_count !== CW'(14)) begin n_fail++; $display("FAIL bp_count_14: got %0d expected 14", fifo_count); end
            end
            if (i == 16) begin
                n_checks += 2;
                if (fifo_count !== CW'(16)) begin n_fail++; $display("FAIL bp_count_16: got %0d expected 16", fifo_count); end
                if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow_16: got %b expected 0", overflow); end
            end
            if (i == 17) begin
                n_checks += 2;
                if (fifo_count !== CW'(16)) begin n_fail++; $display("FAIL bp_count_17: got %0d expected 16", fifo_count); end
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow_17: got %b expected 1", overflow); end
            end
            @(negedge clk);
        end
        force_busy = 1'b0;
        wait_rx(16, 400, ok);
        repeat (busy_len + 10) @(negedge clk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d bytes expected 16", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] got = rx_q.pop_front();
            logic [7:0] exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL bp_order: got %h expected %h", got, exp); end
        end
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra bytes expected 0", rx_q.size()); end
        $display("test_backpressure done");
    endtask

    task automatic test_simul_push_pop();
        bit ok;
        int g0;
        do_reset(3);
        g0 = data_glitches;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h20 + 8'(i), 1'b1);
            @(negedge clk);
        end
        n_checks++;
        if (fifo_count !== CW'(16)) begin n_fail++; $display("FAIL simul_full: got %0d expected 16", fifo_count); end
        bus.stdout    = 8'hA5;
        bus.stdout_en = 1'b1;
        force_busy    = 1'b0;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.stdout_en = 1'b0;
        n_checks += 4;
        if (fifo_count !== CW'(16)) begin n_fail++; $display("FAIL simul_count: got %0d expected 16", fifo_count); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %b expected 0", overflow); end
        if (bus.uart_start !== 1'b1) begin n_fail++; $display("FAIL simul_start: got %b expected 1", bus.uart_start); end
        if (bus.uart_data !== 8'h20) begin n_fail++; $display("FAIL simul_data: got %h expected 20", bus.uart_data); end
        wait_rx(17, 400, ok);
        repeat (busy_len + 10) @(negedge clk);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL simul_timeout: got %0d bytes expected 17", rx_q.size()); end
        if (data_glitches != g0) begin n_fail++; $display("FAIL simul_data_stable: got %0d changes expected 0", data_glitches - g0); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] got = rx_q.pop_front();
            logic [7:0] exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL simul_order: got %h expected %h", got, exp); end
        end
        $display("test_simul_push_pop done");
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        force_busy = 1'b1;
        busy_len   = 100;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h60 + 8'(i), 1'b1);
            @(negedge clk);
        end
        force_busy = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.uart_start !== 1'b1) begin n_fail++; $display("FAIL mid_in_start: got %b expected 1", bus.uart_start); end
        if (fifo_count !== CW'(3)) begin n_fail++; $display("FAIL mid_queued: got %0d expected 3", fifo_count); end
        reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (bus.uart_start !== 1'b0) begin n_fail++; $display("FAIL mid_start_cleared: got %b expected 0", bus.uart_start); end
        if (fifo_count !== '0) begin n_fail++; $display("FAIL mid_count_cleared: got %0d expected 0", fifo_count); end
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_en: got %b expected 0", bus.cpu_en); end
        reset = 1'b0;
        clear_sb();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_en_release: got %b expected 1", bus.cpu_en); end
        repeat (busy_len + 50) @(negedge clk);
        n_checks += 2;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_stale: got %0d bytes expected 0", rx_q.size()); end
        if (pulse_q.size() != 0) begin n_fail++; $display("FAIL mid_stale_start: got %0d strobes expected 0", pulse_q.size()); end
        busy_len = 4;
        $display("test_reset_mid done");
    endtask

    initial begin
        reset         = 1'b1;
        bus.stdout    = 8'h00;
        bus.stdout_en = 1'b0;
        test_reset();
        test_single_byte();
        test_level_hold();
        test_burst_order();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
